masked_arith_unit: RTL and testbench
====================================

# masked_arith_unit

Share-domain integer arithmetic unit: generalised successor of the masked adder/subtractor with add, subtract, signed and unsigned set-less-than. Uses an iterative Kogge-Stone prefix network built from DOM masked AND gates. Handles any width and share count, with a full valid/ready handshake on both request and response. Sits beside the masked multiplier in the masked execute stage; operands and result never leave the share domain.

## Interface
Parameters:
- DWIDTH, 32, operand width; must be ≥ 4.
- SHARES, 2, number of Boolean shares; must be ≥ 2.
- Derived (localparam):
  - AW = DWIDTH+1, internal adder width.
  - STAGES = $clog2(AW).
  - PAIRS = SHARES*(SHARES-1)/2.

Ports:
- ClkxCI, in, 1, clock; one clock domain.
- RstxBI, in, 1, reset; synchronous, active-low.
- ReqValidxSI, in, 1, request valid.
- ReqReadyxSO, out, 1, request ready.
- ReqOpxSI, in, 2, operation select: 0 ADD, 1 SUB, 2 SLT, 3 SLTU.
- ReqIn1xDI, in, DWIDTH*SHARES, operand A; share j in bits [DWIDTH*j +: DWIDTH].
- ReqIn2xDI, in, DWIDTH*SHARES, operand B; same share layout.
- RandomDOM1xDI, in, AW*PAIRS, fresh randomness for the G-path AND gates; pair p in bits [AW*p +: AW].
- RandomDOM2xDI, in, AW*PAIRS, fresh randomness for the P-path AND gates; same layout.
- RespValidxSO, out, 1, result valid.
- RespReadyxSI, in, 1, result accepted.
- RespResultxDO, out, DWIDTH*SHARES, shared result.

## Operation
States:
- IDLE: ReqReadyxSO=1. On ReqValidxSI, latch the op, go to COMPUTE, counter=1.
- COMPUTE: runs exactly STAGES cycles, one prefix level per cycle. After the last level, register the result and go to RESP.
- RESP: RespValidxSO=1 and the result is held stable. On RespReadyxSI, go to IDLE.

Operand preparation, all linear and per share:
- Both operands are extended to AW bits:
  - ADD/SUB: extension bit 0.
  - SLT: each share's own MSB.
  - SLTU: 0.
- SUB/SLT/SLTU invert share 0 of B (all AW bits) and set carry-in share 0 to 1. Other carry-in shares are 0.

Prefix algorithm:
- P0 = A^B. Initial G = A&B via DOM AND, computed in the accept cycle.
- Level k, with s = 2^(k-1):
  - G ← G ^ (P & (G<<s, carry-in at bit s-1, zero below)).
  - P ← P & (P<<s).
- P update is skipped on the final level.

Result:
- Sum share j = P0_j ^ {G_j[AW-2:0], cin_j}.
- ADD/SUB: RespResultxDO = sum bits [DWIDTH-1:0], per share; wraps modulo 2^DWIDTH.
- SLT/SLTU: bit 0 of share j = sum bit DWIDTH of share j; all other bits 0 in every share.

Masking rules:
- No unmasked value is formed anywhere.
- The randomness inputs must be fresh in every cycle in which the DOM gates are enabled (accept cycle plus all COMPUTE cycles). The gates are clock-gated otherwise.

## Timing
Handshake:
- ReqReadyxSO is a combinational function of state only; no combinational path from ReqValidxSI.
- It is forced to 0 while RstxBI=0.
- Request accepted at cycle t. COMPUTE occupies t+1 … t+STAGES. RespValidxSO rises at t+STAGES+1.
- STAGES = 6 for DWIDTH=32, so the response appears 7 cycles after accept.
- Back-to-back throughput: one op per STAGES+2 cycles with RespReadyxSI held high.
- ReqIn*, ReqOpxSI and the randomness are sampled only in the accept cycle; later changes have no effect.
- RespResultxDO stays stable while RespValidxSO=1 && RespReadyxSI=0; the unit stalls indefinitely.

Reset:
- RstxBI=0 at any edge forces IDLE, counter 0, RespValidxSO=0, RespResultxDO=0 and internal G=0, whatever the state.
- An in-flight op is discarded and no response is produced.
- ReqReadyxSO returns to 1 in the first cycle with RstxBI=1.

## Structure
Shared package masked_pkg holds:
- op encoding localparams OP_ADD/OP_SUB/OP_SLT/OP_SLTU;
- the state encoding S_IDLE/S_COMPUTE/S_RESP.

Per-bit DOM gates reuse the existing masked_and_or sub-module with OPERATOR "AND": AW instances on the G path and AW on the P path.

Shift muxes are generated from STAGES; there are no hard-coded per-width cases.

## Test plan
Bench: DWIDTH=32, SHARES=2, random shares and randomness, result checked after XOR-recombining the shares.
- ADD 0xFFFFFFFF + 0x00000001 → 0x00000000, RespValidxSO exactly 7 cycles after accept.
- SUB 0x00000005 − 0x00000007 → 0xFFFFFFFE; SUB 0x80000000 − 1 → 0x7FFFFFFF.
- SLT A=0x80000000, B=0x00000001 → 1. SLTU on the same operands → 0. SLT with A=B → 0.
- RespReadyxSI low for 10 cycles:
  - RespValidxSO stays high and the result is unchanged;
  - ReqReadyxSO=0 throughout;
  - a new request is accepted in the cycle after the response handshake.
- RstxBI low at COMPUTE cycle 3 → next cycle RespValidxSO=0 and RespResultxDO=0. ReqReadyxSO=1 after release, and no stale response appears.
- DWIDTH=8, SHARES=3, 2000 random ops of all four types vs a reference model: zero mismatches, latency STAGES+1=5.

Source files
------------

// File: rtl/masked_pkg.sv
// Shared definitions for the masked execute-stage units: op codes, FSM states,
// and the share-pair numbering used to index DOM randomness.
package masked_pkg;

    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_SUB  = 2'd1;
    localparam logic [1:0] OP_SLT  = 2'd2;
    localparam logic [1:0] OP_SLTU = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_RESP    = 2'd2
    } state_t;

    // Index of the unordered share pair (i, j), i < j, among n shares.
    // Pairs are numbered (0,1), (0,2), ..., (0,n-1), (1,2), ...
    function automatic int pair_index(input int i, input int j, input int n);
        return i * n - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

endpackage

// File: rtl/masked_and_or.sv
// One-bit DOM-independent masked AND (or OR via De Morgan on share 0).
// All partial products are registered before recombination, so the output
// is valid one enabled cycle after the inputs; randomness is consumed then.
module masked_and_or
    import masked_pkg::*;
#(
    parameter int    SHARES   = 2,
    parameter string OPERATOR = "AND"
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              en,
    input  logic [SHARES-1:0]                 x,
    input  logic [SHARES-1:0]                 y,
    input  logic [SHARES*(SHARES-1)/2-1:0]    z,
    output logic [SHARES-1:0]                 q
);

    // OR is built as NOT(AND(NOT x, NOT y)); negating a shared value only
    // touches share 0.
    localparam logic FLIP = (OPERATOR == "OR");

    logic [SHARES-1:0]             xs;
    logic [SHARES-1:0]             ys;
    logic [SHARES-1:0]             qs;
    logic [SHARES-1:0][SHARES-1:0] term_next;
    logic [SHARES-1:0][SHARES-1:0] term_reg;

    assign xs = x ^ {{(SHARES-1){1'b0}}, FLIP};
    assign ys = y ^ {{(SHARES-1){1'b0}}, FLIP};

    genvar gi, gj;
    generate
        for (gi = 0; gi < SHARES; gi++) begin : g_row
            for (gj = 0; gj < SHARES; gj++) begin : g_col
                if (gi == gj) begin : g_inner
                    assign term_next[gi][gj] = xs[gi] & ys[gj];
                end else if (gi < gj) begin : g_cross_lo
                    assign term_next[gi][gj] = (xs[gi] & ys[gj]) ^ z[pair_index(gi, gj, SHARES)];
                end else begin : g_cross_hi
                    assign term_next[gi][gj] = (xs[gi] & ys[gj]) ^ z[pair_index(gj, gi, SHARES)];
                end
            end
            assign qs[gi] = ^term_reg[gi];
        end
    endgenerate

    // Register every partial product; hold when the gate is idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            term_reg <= '0;
        end else if (en) begin
            term_reg <= term_next;
        end
    end

    assign q = qs ^ {{(SHARES-1){1'b0}}, FLIP};

endmodule

// File: rtl/masked_arith_unit.sv
// Share-domain ADD/SUB/SLT/SLTU using an iterative Kogge-Stone prefix
// network of DOM AND gates, one prefix level per cycle.
module masked_arith_unit
    import masked_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int SHARES = 2
) (
    input  logic                                         ClkxCI,
    input  logic                                         RstxBI,
    input  logic                                         ReqValidxSI,
    output logic                                         ReqReadyxSO,
    input  logic [1:0]                                   ReqOpxSI,
    input  logic [DWIDTH*SHARES-1:0]                     ReqIn1xDI,
    input  logic [DWIDTH*SHARES-1:0]                     ReqIn2xDI,
    input  logic [(DWIDTH+1)*(SHARES*(SHARES-1)/2)-1:0]  RandomDOM1xDI,
    input  logic [(DWIDTH+1)*(SHARES*(SHARES-1)/2)-1:0]  RandomDOM2xDI,
    output logic                                         RespValidxSO,
    input  logic                                         RespReadyxSI,
    output logic [DWIDTH*SHARES-1:0]                     RespResultxDO
);

    localparam int AW     = DWIDTH + 1;
    localparam int STAGES = $clog2(AW);
    localparam int PAIRS  = SHARES * (SHARES - 1) / 2;
    localparam int CW     = $clog2(STAGES + 1);

    state_t          state_reg, state_next;
    logic [CW-1:0]   counter_reg, counter_next;
    logic [1:0]      op_reg;
    logic            accept, compute, g_en, p_en;
    logic            inv_b, sext, is_cmp;

    logic [SHARES-1:0][AW-1:0] a_ext, b_ext, p0_in, one_sh;
    logic [SHARES-1:0]         cin_in, cin_reg;
    logic [SHARES-1:0][AW-1:0] p0_reg, gx_reg, g_and, p_and, g_eff, sum;
    logic [SHARES-1:0][AW-1:0] g_x, g_y, p_x, p_y, g_shift_sel, p_shift_sel;
    logic [STAGES-1:0][SHARES-1:0][AW-1:0] g_shift, p_shift;

    assign inv_b  = (ReqOpxSI != OP_ADD);
    assign sext   = (ReqOpxSI == OP_SLT);
    assign is_cmp = (op_reg == OP_SLT) || (op_reg == OP_SLTU);

    genvar gi, gs, gp;
    generate
        // Linear, per-share operand preparation: extend, invert B share 0, carry-in.
        for (gi = 0; gi < SHARES; gi++) begin : g_prep
            assign a_ext[gi]  = {sext & ReqIn1xDI[DWIDTH*gi + DWIDTH-1], ReqIn1xDI[DWIDTH*gi +: DWIDTH]};
            assign b_ext[gi]  = {sext & ReqIn2xDI[DWIDTH*gi + DWIDTH-1], ReqIn2xDI[DWIDTH*gi +: DWIDTH]}
                                ^ {AW{inv_b & (gi == 0)}};
            assign cin_in[gi] = inv_b & (gi == 0);
            assign p0_in[gi]  = a_ext[gi] ^ b_ext[gi];
            // Shared all-ones: lets the P gate load P0 in the accept cycle.
            assign one_sh[gi] = {AW{gi == 0}};
            // G is kept as a partner register XOR the registered gate output.
            assign g_eff[gi]  = gx_reg[gi] ^ g_and[gi];
            assign sum[gi]    = p0_reg[gi] ^ {g_eff[gi][AW-2:0], cin_reg[gi]};
            assign RespResultxDO[DWIDTH*gi +: DWIDTH] =
                !RespValidxSO ? '0 :
                (is_cmp ? {{(DWIDTH-1){1'b0}}, sum[gi][DWIDTH]} : sum[gi][DWIDTH-1:0]);
        end

        // Shifted operands for every prefix level; carry-in enters at bit s-1.
        for (gi = 0; gi < STAGES; gi++) begin : g_level
            for (gs = 0; gs < SHARES; gs++) begin : g_share
                assign g_shift[gi][gs] = (g_eff[gs] << (1 << gi))
                                       | (AW'(cin_reg[gs]) << ((1 << gi) - 1));
                assign p_shift[gi][gs] = p_and[gs] << (1 << gi);
            end
        end

        // Per-bit DOM gates; shares and pair randomness are regrouped per bit.
        for (gi = 0; gi < AW; gi++) begin : g_bit
            logic [SHARES-1:0] gxb, gyb, pxb, pyb, gqb, pqb;
            logic [PAIRS-1:0]  gzb, pzb;
            for (gs = 0; gs < SHARES; gs++) begin : g_sh
                assign gxb[gs]        = g_x[gs][gi];
                assign gyb[gs]        = g_y[gs][gi];
                assign pxb[gs]        = p_x[gs][gi];
                assign pyb[gs]        = p_y[gs][gi];
                assign g_and[gs][gi]  = gqb[gs];
                assign p_and[gs][gi]  = pqb[gs];
            end
            for (gp = 0; gp < PAIRS; gp++) begin : g_pair
                assign gzb[gp] = RandomDOM1xDI[AW*gp + gi];
                assign pzb[gp] = RandomDOM2xDI[AW*gp + gi];
            end
            masked_and_or #(.SHARES(SHARES), .OPERATOR("AND")) u_g_and (
                .clk(ClkxCI), .rst_n(RstxBI), .en(g_en),
                .x(gxb), .y(gyb), .z(gzb), .q(gqb)
            );
            masked_and_or #(.SHARES(SHARES), .OPERATOR("AND")) u_p_and (
                .clk(ClkxCI), .rst_n(RstxBI), .en(p_en),
                .x(pxb), .y(pyb), .z(pzb), .q(pqb)
            );
        end
    endgenerate

    // Pick the shift amount for the current prefix level.
    always_comb begin
        g_shift_sel = g_shift[0];
        p_shift_sel = p_shift[0];
        for (int k = 0; k < STAGES; k++) begin
            if (counter_reg == CW'(k + 1)) begin
                g_shift_sel = g_shift[k];
                p_shift_sel = p_shift[k];
            end
        end
    end

    // Accept cycle: G = A&B, P = P0&1; later cycles run one prefix level each.
    assign g_x  = accept ? a_ext  : p_and;
    assign g_y  = accept ? b_ext  : g_shift_sel;
    assign p_x  = accept ? p0_in  : p_and;
    assign p_y  = accept ? one_sh : p_shift_sel;
    assign g_en = accept | compute;
    assign p_en = accept | (compute && (counter_reg != CW'(STAGES)));

    // FSM state and level counter.
    always_ff @(posedge ClkxCI) begin
        if (!RstxBI) begin
            state_reg   <= S_IDLE;
            counter_reg <= '0;
        end else begin
            state_reg   <= state_next;
            counter_reg <= counter_next;
        end
    end

    // Next state, handshake outputs and gate enables.
    always_comb begin
        state_next   = state_reg;
        counter_next = counter_reg;
        ReqReadyxSO  = 1'b0;
        RespValidxSO = 1'b0;
        accept       = 1'b0;
        compute      = 1'b0;
        case (state_reg)
            S_IDLE: begin
                ReqReadyxSO = RstxBI;
                if (RstxBI && ReqValidxSI) begin
                    accept       = 1'b1;
                    state_next   = S_COMPUTE;
                    counter_next = CW'(1);
                end
            end
            S_COMPUTE: begin
                compute = 1'b1;
                if (counter_reg == CW'(STAGES)) begin
                    state_next   = S_RESP;
                    counter_next = '0;
                end else begin
                    counter_next = counter_reg + CW'(1);
                end
            end
            S_RESP: begin
                RespValidxSO = 1'b1;
                if (RespReadyxSI) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Operand-side state captured at accept; G partner tracks each level.
    always_ff @(posedge ClkxCI) begin
        if (!RstxBI) begin
            op_reg  <= OP_ADD;
            p0_reg  <= '0;
            cin_reg <= '0;
            gx_reg  <= '0;
        end else if (accept) begin
            op_reg  <= ReqOpxSI;
            p0_reg  <= p0_in;
            cin_reg <= cin_in;
            gx_reg  <= '0;
        end else if (compute) begin
            gx_reg  <= g_eff;
        end
    end

endmodule

// File: tb/tb_masked_arith_unit.sv
// Bench for masked_arith_unit: directed cases at DWIDTH=32/SHARES=2 and
// randomized ops at DWIDTH=8/SHARES=3 against an arithmetic reference model.
module tb_masked_arith_unit;

    logic clk = 1'b0;
    logic rst_n;

    logic        v32, rdy32, rv32, rr32;
    logic [1:0]  op32;
    logic [63:0] in1_32, in2_32, res32;
    logic [32:0] rnd1_32, rnd2_32;

    logic        v8, rdy8, rv8, rr8;
    logic [1:0]  op8;
    logic [23:0] in1_8, in2_8, res8;
    logic [26:0] rnd1_8, rnd2_8;

    int n_cmp = 0;
    int n_err = 0;

    masked_arith_unit #(.DWIDTH(32), .SHARES(2)) u_dut32 (
        .ClkxCI(clk), .RstxBI(rst_n),
        .ReqValidxSI(v32), .ReqReadyxSO(rdy32), .ReqOpxSI(op32),
        .ReqIn1xDI(in1_32), .ReqIn2xDI(in2_32),
        .RandomDOM1xDI(rnd1_32), .RandomDOM2xDI(rnd2_32),
        .RespValidxSO(rv32), .RespReadyxSI(rr32), .RespResultxDO(res32)
    );

    masked_arith_unit #(.DWIDTH(8), .SHARES(3)) u_dut8 (
        .ClkxCI(clk), .RstxBI(rst_n),
        .ReqValidxSI(v8), .ReqReadyxSO(rdy8), .ReqOpxSI(op8),
        .ReqIn1xDI(in1_8), .ReqIn2xDI(in2_8),
        .RandomDOM1xDI(rnd1_8), .RandomDOM2xDI(rnd2_8),
        .RespValidxSO(rv8), .RespReadyxSI(rr8), .RespResultxDO(res8)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and refresh the DOM randomness for the next cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        rnd1_32 = 33'({$urandom(), $urandom()});
        rnd2_32 = 33'({$urandom(), $urandom()});
        rnd1_8  = 27'($urandom());
        rnd2_8  = 27'($urandom());
    endtask

    function automatic logic [63:0] share32(input logic [31:0] v);
        logic [31:0] r;
        r = $urandom();
        return {v ^ r, r};
    endfunction

    function automatic logic [23:0] share8(input logic [7:0] v);
        logic [7:0] r0, r1;
        r0 = 8'($urandom());
        r1 = 8'($urandom());
        return {v ^ r0 ^ r1, r1, r0};
    endfunction

    function automatic logic [7:0] ref8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
            default: return (a < b) ? 8'd1 : 8'd0;
        endcase
    endfunction

    function automatic logic [7:0] pick8();
        case ($urandom_range(0, 5))
            0:       return 8'h00;
            1:       return 8'h7F;
            2:       return 8'h80;
            3:       return 8'hFF;
            default: return 8'($urandom());
        endcase
    endfunction

    task automatic do_op32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input int stall, input string tag);
        int lat;
        check({tag, "_req_ready"}, 64'(rdy32), 64'd1);
        op32 = op; in1_32 = share32(a); in2_32 = share32(b); v32 = 1'b1;
        tick();
        v32 = 1'b0; op32 = 2'($urandom()); in1_32 = share32($urandom()); in2_32 = share32($urandom());
        lat = 1;
        while (!rv32 && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd7);
        check({tag, "_result"}, 64'(res32[31:0] ^ res32[63:32]), 64'(exp));
        for (int i = 0; i < stall; i++) begin
            tick();
            check({tag, "_stall_valid"}, 64'(rv32), 64'd1);
            check({tag, "_stall_result"}, 64'(res32[31:0] ^ res32[63:32]), 64'(exp));
            check({tag, "_stall_req_ready"}, 64'(rdy32), 64'd0);
        end
        rr32 = 1'b1;
        tick();
        rr32 = 1'b0;
        check({tag, "_resp_done"}, 64'(rv32), 64'd0);
        $display("txn32 %s op=%0d a=%h b=%h exp=%h lat=%0d", tag, op, a, b, exp, lat);
    endtask

    task automatic do_op8(input int idx);
        logic [1:0] op;
        logic [7:0] a, b, exp, got;
        int lat, stall;
        op = 2'($urandom_range(0, 3));
        a = pick8();
        b = ($urandom_range(0, 7) == 0) ? a : pick8();
        exp = ref8(op, a, b);
        stall = $urandom_range(0, 2);
        check("r8_req_ready", 64'(rdy8), 64'd1);
        op8 = op; in1_8 = share8(a); in2_8 = share8(b); v8 = 1'b1;
        tick();
        v8 = 1'b0; op8 = 2'($urandom()); in1_8 = 24'($urandom()); in2_8 = 24'($urandom());
        lat = 1;
        while (!rv8 && lat < 40) begin
            tick();
            lat++;
        end
        check("r8_latency", 64'(lat), 64'd5);
        got = res8[7:0] ^ res8[15:8] ^ res8[23:16];
        check("r8_result", 64'(got), 64'(exp));
        if (op == 2'd2 || op == 2'd3) begin
            check("r8_cmp_upper_zero", 64'(res8 & 24'hFEFEFE), 64'd0);
        end
        for (int i = 0; i < stall; i++) begin
            tick();
            check("r8_stall_valid", 64'(rv8), 64'd1);
        end
        rr8 = 1'b1;
        tick();
        rr8 = 1'b0;
        $display("txn8 #%0d op=%0d a=%h b=%h res=%h exp=%h lat=%0d", idx, op, a, b, got, exp, lat);
    endtask

    initial begin
        rst_n = 1'b0;
        v32 = 1'b0; rr32 = 1'b0; op32 = 2'd0; in1_32 = '0; in2_32 = '0;
        v8  = 1'b0; rr8  = 1'b0; op8  = 2'd0; in1_8  = '0; in2_8  = '0;
        rnd1_32 = '0; rnd2_32 = '0; rnd1_8 = '0; rnd2_8 = '0;
        repeat (3) tick();
        check("rst_req_ready32", 64'(rdy32), 64'd0);
        check("rst_req_ready8", 64'(rdy8), 64'd0);
        check("rst_resp_valid32", 64'(rv32), 64'd0);
        check("rst_result32", res32, 64'd0);
        rst_n = 1'b1;
        #1;
        check("rel_req_ready32", 64'(rdy32), 64'd1);
        tick();

        // Directed cases at 32 bits.
        do_op32(2'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 0, "add_wrap");
        do_op32(2'd1, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 0, "sub_neg");
        do_op32(2'd1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 0, "sub_min");
        do_op32(2'd2, 32'h80000000, 32'h00000001, 32'h00000001, 0, "slt_neg");
        do_op32(2'd3, 32'h80000000, 32'h00000001, 32'h00000000, 0, "sltu_big");
        do_op32(2'd2, 32'h12345678, 32'h12345678, 32'h00000000, 0, "slt_eq");
        do_op32(2'd0, 32'h12345678, 32'h11111111, 32'h23456789, 10, "add_stall");
        do_op32(2'd1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 0, "sub_after_stall");

        // Reset during the third COMPUTE cycle discards the op.
        check("rst_mid_req_ready", 64'(rdy32), 64'd1);
        op32 = 2'd0; in1_32 = share32(32'h0000FFFF); in2_32 = share32(32'h00000001); v32 = 1'b1;
        tick();
        v32 = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("rst_mid_resp_valid", 64'(rv32), 64'd0);
        check("rst_mid_result", res32, 64'd0);
        check("rst_mid_req_ready_low", 64'(rdy32), 64'd0);
        rst_n = 1'b1;
        #1;
        check("rst_mid_req_ready_back", 64'(rdy32), 64'd1);
        for (int i = 0; i < 12; i++) begin
            tick();
            check("rst_mid_no_stale", 64'(rv32), 64'd0);
        end
        $display("txn32 rst_mid discarded in-flight op");
        do_op32(2'd3, 32'h00000001, 32'h80000000, 32'h00000001, 0, "sltu_after_rst");

        // Randomized ops at 8 bits, 3 shares.
        for (int n = 0; n < 2000; n++) begin
            do_op8(n);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
